// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// and the default memory-ack timeout.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and the
// legality check for an incoming request, plus load extraction/extension
// from the returned memory word using the latched access size and offset.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_data
);

    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;

    // Request side: size decode from funct3[1:0], then direction-specific checks.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata;
        illegal   = 1'b0;
        case (req_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << req_off;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << req_off;
                wdata_rep = {2{req_wdata[15:0]}};
                illegal   = req_off[0];
            end
            2'b10: begin
                be      = 4'b1111;
                illegal = (req_off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
        // Stores have no unsigned variants; loads have no 110/111 codes.
        if (req_store && req_funct3[2])
            illegal = 1'b1;
        if (!req_store && (req_funct3 == 3'b110))
            illegal = 1'b1;
    end

    // Load side: pick the addressed lane and extend it according to funct3.
    always_comb begin
        b_s = mem_rdata[{ld_off, 3'b000} +: 8];
        h_s = mem_rdata[{ld_off[1], 4'b0000} +: 16];
        case (ld_funct3)
            F3_B:    ld_data = 32'(b_s);
            F3_BU:   ld_data = {24'h000000, b_s};
            F3_H:    ld_data = 32'(h_s);
            F3_HU:   ld_data = {16'h0000, h_s};
            default: ld_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit top: accepts one request at a time, runs the req/ack
// handshake with data memory, and returns the extended load result with a
// done pulse (plus err on misalignment, illegal funct3 or ack timeout).
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_off;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] ld_data;
    logic        illegal;
    logic        tmo_hit;

    lsu_align u_align (
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .illegal    (illegal),
        .ld_funct3  (ld_funct3),
        .ld_off     (ld_off),
        .mem_rdata  (mem_rdata),
        .ld_data    (ld_data)
    );

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_RESP);
    assign tmo_hit = (cnt == TMO_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Next-state: illegal requests skip the bus; ack beats a coincident timeout.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (req_valid) state_n = illegal ? S_RESP : S_WAIT;
            S_WAIT:  if (mem_ack || tmo_hit) state_n = S_RESP;
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Bus outputs, timeout counter, load result and fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 8'd0;
            ld_funct3 <= 3'b000;
            ld_off    <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ld_funct3 <= req_funct3;
                        ld_off    <= req_addr[1:0];
                        mem_we    <= req_store;
                        mem_be    <= be;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= wdata_rep;
                        mem_req   <= !illegal;
                        err       <= illegal;
                        cnt       <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        // mem_we still carries the latched store flag.
                        if (!mem_we)
                            rdata <= ld_data;
                    end else if (tmo_hit) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: err <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: loads, stores, faults, timeout, reset
// mid-transaction and back-to-back requests.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_if #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #3;
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_rdata",   rdata,        32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LB from 0x103, ack on first WAIT cycle
        mem_rdata = 32'h80FF_1234;
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        chk("lb_mem_req",  32'(mem_req), 32'd1);
        chk("lb_mem_addr", mem_addr,     32'h0000_0100);
        chk("lb_mem_be",   32'(mem_be),  32'h8);
        chk("lb_mem_we",   32'(mem_we),  32'd0);
        chk("lb_busy",     32'(busy),    32'd1);
        chk("lb_nodone",   32'(done),    32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lb_done",     32'(done),    32'd1);
        chk("lb_err",      32'(err),     32'd0);
        chk("lb_rdata",    rdata,        32'hFFFF_FF80);
        chk("lb_req_low",  32'(mem_req), 32'd0);
        @(negedge clk);
        chk("lb_idle",     32'(busy),    32'd0);

        // LBU same access
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lbu_done",  32'(done), 32'd1);
        chk("lbu_rdata", rdata,     32'h0000_0080);
        @(negedge clk);

        // SH to 0x202, ack on the fourth WAIT cycle
        issue(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF);
        chk("sh_mem_we",    32'(mem_we),  32'd1);
        chk("sh_mem_be",    32'(mem_be),  32'hC);
        chk("sh_mem_wdata", mem_wdata,    32'hBEEF_BEEF);
        chk("sh_mem_addr",  mem_addr,     32'h0000_0200);
        chk("sh_req_c1",    32'(mem_req), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            chk("sh_req_hold",   32'(mem_req), 32'd1);
            chk("sh_wdata_hold", mem_wdata,    32'hBEEF_BEEF);
            chk("sh_be_hold",    32'(mem_be),  32'hC);
            chk("sh_nodone",     32'(done),    32'd0);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("sh_req_low", 32'(mem_req), 32'd0);
        chk("sh_done",    32'(done),    32'd1);
        chk("sh_err",     32'(err),     32'd0);
        chk("sh_rdata",   rdata,        32'h0000_0080);
        @(negedge clk);

        // SB to 0x001: single lane, byte replicated
        issue(1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5);
        chk("sb_mem_be",    32'(mem_be), 32'h2);
        chk("sb_mem_wdata", mem_wdata,   32'hA5A5_A5A5);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("sb_done",  32'(done), 32'd1);
        @(negedge clk);

        // Misaligned LW from 0x105
        issue(1'b0, 3'b010, 32'h0000_0105, 32'h0);
        chk("mis_busy",    32'(busy),    32'd1);
        chk("mis_done",    32'(done),    32'd1);
        chk("mis_err",     32'(err),     32'd1);
        chk("mis_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("mis_busy_1cy", 32'(busy), 32'd0);
        chk("mis_err_pulse", 32'(err), 32'd0);

        // Illegal load funct3 011
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        chk("ill_err",     32'(err),     32'd1);
        chk("ill_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);

        // LW with no ack: timeout after 16 WAIT cycles
        issue(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            chk("tmo_nodone", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("tmo_req_cycles", 32'(n),  32'd16);
        chk("tmo_done",       32'(done), 32'd1);
        chk("tmo_err",        32'(err),  32'd1);
        chk("tmo_rdata",      rdata,     32'h0000_0080);
        @(negedge clk);
        chk("tmo_idle", 32'(busy), 32'd0);

        // Reset asserted during WAIT
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        @(negedge clk);
        chk("rmid_req_before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_req_async", 32'(mem_req), 32'd0);
        chk("rmid_busy",      32'(busy),    32'd0);
        chk("rmid_done",      32'(done),    32'd0);
        chk("rmid_rdata",     rdata,        32'h0);
        @(negedge clk);
        chk("rmid_nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LHU from 0x002 after reset
        mem_rdata = 32'h8001_0000;
        issue(1'b0, 3'b101, 32'h0000_0002, 32'h0);
        chk("lhu_mem_be", 32'(mem_be), 32'hC);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("lhu_done",  32'(done), 32'd1);
        chk("lhu_rdata", rdata,     32'h0000_8001);
        @(negedge clk);

        // Back-to-back: req_valid held high through the transaction
        mem_rdata  = 32'h1234_5678;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0010;
        @(negedge clk);
        chk("b2b_req1", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("b2b_done1",  32'(done),    32'd1);
        chk("b2b_rdata1", rdata,        32'h1234_5678);
        chk("b2b_req_lo", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("b2b_idle",   32'(busy),    32'd0);
        chk("b2b_req_lo2", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("b2b_req2",   32'(mem_req), 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_done2",  32'(done), 32'd1);
        @(negedge clk);

        // Stray ack with no request outstanding
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        @(negedge clk);
        chk("stray_busy",  32'(busy),    32'd0);
        chk("stray_done",  32'(done),    32'd0);
        chk("stray_req",   32'(mem_req), 32'd0);
        chk("stray_rdata", rdata,        32'h1234_5678);
        mem_ack = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
